mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It extends the CPU datapath's single-cycle ALU with MULT, MULTU, DIV, DIVU, MTHI and MTLO for a W-bit datapath. It sits beside the ALU and is driven by the multicycle controller. The controller issues a one-cycle start, stalls on busy, and reads HI/LO for MFHI/MFLO through the write-back mux.

## Interface
- W, 32, operand width (≥2); HI and LO are W bits each.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; latched with start.
- a  in  W  multiplicand / dividend (rs); latched with start.
- b  in  W  multiplier / divisor (rt); latched with start.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  W  MTHI/MTLO data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO receive a result.
- div_by_zero  out  1  one-cycle pulse with done when a DIV/DIVU had b==0.
- hi  out  W  HI register.
- lo  out  W  LO register.

## Operation
- States: IDLE, CALC, FIX. Iteration counter width is $clog2(W+1).
- **IDLE, start=1:**
  - Latch op.
  - Latch |a| and |b| for signed ops (MULT, DIV); latch raw a and b for unsigned ops.
  - Latch neg_q = a[W-1]^b[W-1] and neg_r = a[W-1]. Both are forced to 0 for unsigned ops.
  - Latch bz = (b==0).
  - Clear the 2W accumulator. Set count=W. Go to CALC.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, 2W-bit product accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle, W+1-bit partial remainder.
- **CALC exit:** decrement count each cycle; go to FIX when count reaches 1.
- **FIX, MULT/MULTU:** {hi,lo} = neg_q ? −product : product, mod 2^(2W).
- **FIX, DIV/DIVU:**
  - lo = neg_q ? −quotient : quotient.
  - hi = neg_r ? −remainder : remainder.
  - All results are mod 2^W.
- **FIX, divide by zero:** when bz=1, override with lo = all-ones and hi = a as latched, raw and signed alike. div_by_zero pulses.
- **FIX exit:** go to IDLE; done pulses.
- **Most-negative operand:** |−2^(W−1)| = 2^(W−1) is representable unsigned, so there is no special case. DIV −2^(W−1) / −1 gives lo=2^(W−1), hi=0.
- **start outside IDLE:** ignored. No queueing.
- **hi_we / lo_we in IDLE without start:** hi ← wdata and/or lo ← wdata on that edge. Both may fire together.
- **hi_we / lo_we with start in the same IDLE cycle:** start wins and the writes are dropped.
- **hi_we / lo_we while busy:** ignored.
- **Reset:** aborts any operation. hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.

## Timing
- start sampled at edge E0. busy=1 from E0 until E(W+1). W iterations occur at E1..EW, then FIX.
- At E(W+1): hi/lo updated, busy→0, done=1 and div_by_zero valid for exactly one cycle.
- Latency: W+1 cycles from the start edge to the result edge (33 cycles for W=32). Every op type takes the same latency, including divide-by-zero.
- A new start can be accepted in the cycle done is high, i.e. back-to-back operations with zero dead cycles.
- hi and lo change only at the FIX edge, at an MTHI/MTLO edge, or on reset. They are stable and readable throughout CALC.
- busy, done and div_by_zero are registered outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back MULT 0x80000000×0x80000000 started in the done cycle -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 for one cycle with done, latency 33.
- MTHI wdata=0xA5A5A5A5 and MTLO wdata=0x5A5A5A5A in IDLE -> hi and lo updated next edge. Repeat with start in the same cycle -> writes dropped. hi_we during busy -> no change.
- Assert rst asynchronously during CALC iteration 10 of a MULT -> hi=lo=0, busy=0, done never pulses. start pulsed during busy -> ignored, and the original result is unaffected.

Source files
------------

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq : iterative W-bit multiply/divide unit with HI/LO registers
// Rev 1.0 : shift-add multiply, restoring divide, MTHI/MTLO writes
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     state, next_state;
  logic [1:0]     op_q;
  logic [W-1:0]   ma, mb;
  logic           neg_q, neg_r, bz;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem;
  logic [CW-1:0]  cnt;

  logic           is_signed;
  logic [W-1:0]   a_abs, b_abs;
  logic [W:0]     sum, trial, diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  logic           busy_d, done_d, dbz_d;

  assign is_signed = op[0];
  assign a_abs     = (is_signed && a[W-1]) ? -a : a;
  assign b_abs     = (is_signed && b[W-1]) ? -b : b;

  assign sum   = {1'b0, acc[2*W-1:W]} + (mb[0] ? {1'b0, ma} : {(W+1){1'b0}});
  assign trial = {rem, ma[W-1]};
  // The partial remainder stays below the divisor, so bit W of the
  // difference is set exactly when the trial subtraction borrows.
  assign diff  = trial - {1'b0, mb};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = bz ? {W{1'b1}} : (neg_q ? -ma : ma);
  assign rem_fix  = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CALC;
      S_CALC:  if (cnt == CW'(1)) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (next_state != S_IDLE);
    done_d = (state == S_FIX);
    dbz_d  = (state == S_FIX) && bz && op_q[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 2'b00;
      ma    <= '0;
      mb    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz    <= 1'b0;
      acc   <= '0;
      rem   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            ma    <= a_abs;
            mb    <= b_abs;
            neg_q <= is_signed & (a[W-1] ^ b[W-1]);
            neg_r <= is_signed & a[W-1];
            bz    <= (b == '0);
            acc   <= '0;
            rem   <= '0;
            cnt   <= CW'(W);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt - CW'(1);
          if (!op_q[1]) begin
            acc <= {sum, acc[W-1:1]};
            mb  <= mb >> 1;
          end else begin
            rem <= diff[W] ? trial[W-1:0] : diff[W-1:0];
            ma  <= {ma[W-2:0], ~diff[W]};
          end
        end
        S_FIX: begin
          if (!op_q[1]) begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq : scoreboard bench for mdu_seq (W=32)
`default_nettype none

module tb_mdu_seq;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];
  exp_t e_mon;

  mdu_seq #(.W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    logic signed [63:0] sx, sy, p, q, m;
    logic [63:0] ux, uy, up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    r.dbz = 1'b0;
    case (o)
      2'b00: begin up = ux * uy; r.hi = up[63:32]; r.lo = up[31:0]; end
      2'b01: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
        end else if (o == 2'b10) begin
          r.lo = x / y; r.hi = x % y;
        end else begin
          q = sx / sy; m = sx % sy;
          r.lo = q[31:0]; r.hi = m[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard side: every done pops one expectation and checks timing.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e_mon = exp_q.pop_front();
          check("hi", {32'b0, hi}, {32'b0, e_mon.hi});
          check("lo", {32'b0, lo}, {32'b0, e_mon.lo});
          check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e_mon.dbz});
          check("latency", 64'(cyc - (t_start + 1)), 64'd33);
          check("busy_cycles", 64'(busy_cnt), 64'd33);
        end
      end else if (div_by_zero) begin
        check("dbz_without_done", 64'd1, 64'd0);
      end
      if (busy) busy_cnt++;
      if (start && !busy) begin
        t_start  = cyc;
        busy_cnt = 0;
      end
    end
  end

  // Caller is always just after a rising edge.
  task automatic issue_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(o, x, y);
    issue_exp(o, x, y, e.hi, e.lo, e.dbz);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      check("done_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue_exp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done();
    issue_exp(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done();
    issue_exp(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    wait_done();

    issue_exp(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done();
    issue_exp(2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    wait_done();
    issue_exp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    wait_done();
    issue_exp(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    issue_exp(2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    @(posedge clk); #1;

    hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mthi", {32'b0, hi}, 64'hA5A5_A5A5);
    check("mtlo", {32'b0, lo}, 64'h5A5A_5A5A);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
    issue_exp(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    lo_we = 1'b0;
    check("start_drops_mthi", {32'b0, hi}, 64'hA5A5_A5A5);
    check("start_drops_mtlo", {32'b0, lo}, 64'h5A5A_5A5A);
    wdata = 32'h2222_2222;
    repeat (4) @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("busy_mthi_ignored", {32'b0, hi}, 64'hA5A5_A5A5);
    wait_done();
    @(posedge clk); #1;

    issue_exp(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    op = 2'b10; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 3) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 15)) : $urandom);
      issue(ro, rx, ry);
      wait_done();
    end
    @(posedge clk); #1;

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    issue_exp(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
